l1_bus_arbiter: RTL and testbench

- Shares the single cache-to-memory bus (Transform interface) between the L1 I-cache and L1 D-cache controllers.
- Each cache FSM requests a line read (refill, ReadBus state) or a line write (writeback, WriteBus state). The arbiter grants one requester at a time, latches its command, drives the bus, and returns a done pulse with the 128-bit line.
- Sits between both cache RAM/FSM blocks and the bus transform unit.

---
 rtl/l1_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_l1_bus_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_bus_arbiter.sv
// rtl/l1_bus_arbiter.sv - shares the cache-to-memory bus between the L1 I-cache and D-cache
// One transaction at a time: grant, hold the latched command on the bus, return a one-cycle done.
module l1_bus_arbiter #(
    parameter bit          DCACHE_PRIORITY = 1'b0,
    parameter logic [15:0] TIMEOUT_CYCLES  = 16'd1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Icache_BusReq,
    input  logic         Icache_BusWr,
    input  logic [31:0]  Icache_BusAddr,
    input  logic [127:0] Icache_BusWrtData,
    output logic         Icache_BusDone,
    output logic         Icache_BusErr,
    input  logic         Dcache_BusReq,
    input  logic         Dcache_BusWr,
    input  logic [31:0]  Dcache_BusAddr,
    input  logic [127:0] Dcache_BusWrtData,
    output logic         Dcache_BusDone,
    output logic         Dcache_BusErr,
    output logic [127:0] Arb_DataRdBuff,
    output logic         Arb_Owner,
    output logic         Bus_Req,
    output logic         Bus_Wr,
    output logic [31:0]  Bus_Addr,
    output logic [127:0] Bus_WrtData,
    input  logic         Transform_BusWrtDone,
    input  logic         Transform_BusRdDone,
    input  logic [127:0] Transform_BusDataRdBuff
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    state_t        state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic          owner_q, owner_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_wr_q, bus_wr_d;
    logic [31:4]   bus_addr_q, bus_addr_d;
    logic [127:0]  bus_wdata_q, bus_wdata_d;
    logic [127:0]  rd_buff_q, rd_buff_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          i_done_q, i_done_d;
    logic          i_err_q, i_err_d;
    logic          d_done_q, d_done_d;
    logic          d_err_q, d_err_d;
    logic          pick;
    logic          bus_done;
    logic          timed_out;

    // Line offset bits never reach the bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Icache_BusAddr[3:0], Dcache_BusAddr[3:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            rd_buff_q    <= '0;
            cnt_q        <= '0;
            i_done_q     <= 1'b0;
            i_err_q      <= 1'b0;
            d_done_q     <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            rd_buff_q    <= rd_buff_d;
            cnt_q        <= cnt_d;
            i_done_q     <= i_done_d;
            i_err_q      <= i_err_d;
            d_done_q     <= d_done_d;
            d_err_q      <= d_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        rd_buff_d    = rd_buff_q;
        cnt_d        = cnt_q;
        i_done_d     = 1'b0;
        i_err_d      = 1'b0;
        d_done_d     = 1'b0;
        d_err_d      = 1'b0;
        pick         = 1'b0;
        bus_done     = 1'b0;
        timed_out    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Icache_BusReq || Dcache_BusReq) begin
                    // On a tie, round-robin hands the bus to whoever did not have it last.
                    if (Icache_BusReq && Dcache_BusReq) begin
                        pick = DCACHE_PRIORITY ? 1'b1 : ~last_owner_q;
                    end else begin
                        pick = Dcache_BusReq;
                    end
                    owner_d      = pick;
                    last_owner_d = pick;
                    bus_req_d    = 1'b1;
                    bus_wr_d     = pick ? Dcache_BusWr : Icache_BusWr;
                    bus_addr_d   = pick ? Dcache_BusAddr[31:4] : Icache_BusAddr[31:4];
                    bus_wdata_d  = pick ? Dcache_BusWrtData : Icache_BusWrtData;
                    cnt_d        = '0;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                bus_done  = bus_wr_q ? Transform_BusWrtDone : Transform_BusRdDone;
                timed_out = (TIMEOUT_CYCLES != 16'd0) && (cnt_q == TIMEOUT_CYCLES - 16'd1);
                if (bus_done || timed_out) begin
                    if (bus_done) begin
                        if (!bus_wr_q) begin
                            rd_buff_d = Transform_BusDataRdBuff;
                        end
                    end else begin
                        rd_buff_d = '0;
                    end
                    bus_req_d = 1'b0;
                    i_done_d  = ~owner_q;
                    d_done_d  = owner_q;
                    i_err_d   = ~owner_q & ~bus_done;
                    d_err_d   = owner_q & ~bus_done;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Icache_BusDone = i_done_q;
    assign Icache_BusErr  = i_err_q;
    assign Dcache_BusDone = d_done_q;
    assign Dcache_BusErr  = d_err_q;
    assign Arb_DataRdBuff = rd_buff_q;
    assign Arb_Owner      = owner_q;
    assign Bus_Req        = bus_req_q;
    assign Bus_Wr         = bus_wr_q;
    assign Bus_Addr       = {bus_addr_q, 4'b0000};
    assign Bus_WrtData    = bus_wdata_q;

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// tb/tb_l1_bus_arbiter.sv - self-checking bench for l1_bus_arbiter
// dut0: round-robin, 8-cycle timeout; dut1: D-cache priority, timeout disabled.
module tb_l1_bus_arbiter;

    typedef struct packed {
        logic         ireq;
        logic         iwr;
        logic [31:0]  iaddr;
        logic [127:0] iwd;
        logic         dreq;
        logic         dwr;
        logic [31:0]  daddr;
        logic [127:0] dwd;
        logic         rdone;
        logic         wdone;
        logic [127:0] rdata;
    } in_t;

    typedef struct packed {
        logic         idone;
        logic         ierr;
        logic         ddone;
        logic         derr;
        logic [127:0] rdbuf;
        logic         owner;
        logic         breq;
        logic         bwr;
        logic [31:0]  baddr;
        logic [127:0] bwd;
    } out_t;

    typedef struct {
        in_t          in;
        logic         breq;
        logic [31:0]  baddr;
        logic [127:0] bwd;
        logic         idone;
        logic         ierr;
        logic         ddone;
        logic         derr;
        logic [127:0] rdbuf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  in0, in1;
    out_t o0, o1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    l1_bus_arbiter #(.DCACHE_PRIORITY(1'b0), .TIMEOUT_CYCLES(16'd8)) dut0 (
        .clk(clk), .rst(rst),
        .Icache_BusReq(in0.ireq), .Icache_BusWr(in0.iwr), .Icache_BusAddr(in0.iaddr),
        .Icache_BusWrtData(in0.iwd), .Icache_BusDone(o0.idone), .Icache_BusErr(o0.ierr),
        .Dcache_BusReq(in0.dreq), .Dcache_BusWr(in0.dwr), .Dcache_BusAddr(in0.daddr),
        .Dcache_BusWrtData(in0.dwd), .Dcache_BusDone(o0.ddone), .Dcache_BusErr(o0.derr),
        .Arb_DataRdBuff(o0.rdbuf), .Arb_Owner(o0.owner), .Bus_Req(o0.breq), .Bus_Wr(o0.bwr),
        .Bus_Addr(o0.baddr), .Bus_WrtData(o0.bwd),
        .Transform_BusWrtDone(in0.wdone), .Transform_BusRdDone(in0.rdone),
        .Transform_BusDataRdBuff(in0.rdata)
    );

    l1_bus_arbiter #(.DCACHE_PRIORITY(1'b1), .TIMEOUT_CYCLES(16'd0)) dut1 (
        .clk(clk), .rst(rst),
        .Icache_BusReq(in1.ireq), .Icache_BusWr(in1.iwr), .Icache_BusAddr(in1.iaddr),
        .Icache_BusWrtData(in1.iwd), .Icache_BusDone(o1.idone), .Icache_BusErr(o1.ierr),
        .Dcache_BusReq(in1.dreq), .Dcache_BusWr(in1.dwr), .Dcache_BusAddr(in1.daddr),
        .Dcache_BusWrtData(in1.dwd), .Dcache_BusDone(o1.ddone), .Dcache_BusErr(o1.derr),
        .Arb_DataRdBuff(o1.rdbuf), .Arb_Owner(o1.owner), .Bus_Req(o1.breq), .Bus_Wr(o1.bwr),
        .Bus_Addr(o1.baddr), .Bus_WrtData(o1.bwd),
        .Transform_BusWrtDone(in1.wdone), .Transform_BusRdDone(in1.rdone),
        .Transform_BusDataRdBuff(in1.rdata)
    );

    // Reference model: ph 0 = waiting, 1 = on the bus, 2 = response cycle; busy_n counts bus cycles used.
    int           m_ph [2];
    int           m_busy_n [2];
    logic         m_last [2];
    logic         m_own [2];
    logic         m_wr [2];
    logic         m_err [2];
    logic [31:0]  m_addr [2];
    logic [127:0] m_wd [2];
    logic [127:0] m_rd [2];
    int           ag [2][2];

    function automatic in_t get_in(input int k);
        return (k == 0) ? in0 : in1;
    endfunction

    function automatic out_t get_out(input int k);
        return (k == 0) ? o0 : o1;
    endfunction

    task automatic set_in(input int k, input in_t v);
        if (k == 0) in0 = v;
        else        in1 = v;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_busy_n[k] = 0; m_last[k] = 1'b1; m_own[k] = 1'b0;
            m_wr[k] = 1'b0; m_err[k] = 1'b0; m_addr[k] = '0; m_wd[k] = '0; m_rd[k] = '0;
            ag[k][0] = 0; ag[k][1] = 0;
        end
    endtask

    task automatic model_step(input int k);
        in_t  x;
        int   tmo;
        logic win;
        logic fin;
        x   = get_in(k);
        tmo = (k == 0) ? 8 : 0;
        if (m_ph[k] == 0) begin
            if (x.ireq || x.dreq) begin
                if (x.ireq && x.dreq) win = (k == 1) ? 1'b1 : !m_last[k];
                else                  win = x.dreq;
                m_own[k]    = win;
                m_last[k]   = win;
                m_wr[k]     = win ? x.dwr : x.iwr;
                m_addr[k]   = (win ? x.daddr : x.iaddr) & 32'hFFFF_FFF0;
                m_wd[k]     = win ? x.dwd : x.iwd;
                m_busy_n[k] = 1;
                m_ph[k]     = 1;
            end
        end else if (m_ph[k] == 1) begin
            fin = m_wr[k] ? x.wdone : x.rdone;
            if (fin) begin
                if (!m_wr[k]) m_rd[k] = x.rdata;
                m_err[k] = 1'b0;
                m_ph[k]  = 2;
            end else if (tmo != 0 && m_busy_n[k] == tmo) begin
                m_rd[k]  = '0;
                m_err[k] = 1'b1;
                m_ph[k]  = 2;
            end else begin
                m_busy_n[k]++;
            end
        end else begin
            m_ph[k] = 0;
        end
    endtask

    task automatic model_check(input int k);
        out_t o;
        logic resp;
        o    = get_out(k);
        resp = (m_ph[k] == 2);
        chk($sformatf("dut%0d_breq", k), o.breq, m_ph[k] == 1);
        chk($sformatf("dut%0d_done_err", k), {o.idone, o.ierr, o.ddone, o.derr},
            {resp && !m_own[k], resp && !m_own[k] && m_err[k], resp && m_own[k], resp && m_own[k] && m_err[k]});
        chk($sformatf("dut%0d_rdbuf", k), o.rdbuf, m_rd[k]);
        if (m_ph[k] == 1) begin
            chk($sformatf("dut%0d_owner_wr_addr", k), {o.owner, o.bwr, o.baddr}, {m_own[k], m_wr[k], m_addr[k]});
            chk($sformatf("dut%0d_wrtdata", k), o.bwd, m_wd[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_step(0);
            model_step(1);
        end
        #1;
        model_check(0);
        model_check(1);
    endtask

    task automatic hard_reset(input string nm);
        out_t o;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            o = get_out(k);
            chk($sformatf("%s_dut%0d_ctl", nm, k), {o.idone, o.ierr, o.ddone, o.derr, o.breq, o.owner, o.bwr}, 7'd0);
            chk($sformatf("%s_dut%0d_rdbuf", nm, k), o.rdbuf, '0);
            chk($sformatf("%s_dut%0d_bus", nm, k), {o.baddr, o.bwd[95:0]}, '0);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Random requester: raise, hold until done (sometimes drop early), then stay low two drives.
    task automatic agents(input int k);
        in_t  x;
        out_t o;
        logic dn;
        logic rq, wr;
        logic [31:0] ad;
        logic [127:0] wd;
        x = get_in(k);
        o = get_out(k);
        for (int c = 0; c < 2; c++) begin
            dn = (c == 0) ? o.idone : o.ddone;
            rq = (c == 0) ? x.ireq : x.dreq;
            wr = (c == 0) ? x.iwr : x.dwr;
            ad = (c == 0) ? x.iaddr : x.daddr;
            wd = (c == 0) ? x.iwd : x.dwd;
            case (ag[k][c])
                0: begin
                    rq = ($urandom % 3 == 0);
                    if (rq) ag[k][c] = 1;
                end
                1: begin
                    if (dn) begin
                        rq = 1'b0; ag[k][c] = 3;
                    end else if ($urandom % 16 == 0) begin
                        rq = 1'b0; ag[k][c] = 2;
                    end
                end
                2: begin
                    rq = 1'b0;
                    if (dn) ag[k][c] = 3;
                end
                default: begin
                    rq = 1'b0; ag[k][c] = 0;
                end
            endcase
            wr = $urandom % 2;
            ad = $urandom;
            wd = {$urandom, $urandom, $urandom, $urandom};
            if (c == 0) begin x.ireq = rq; x.iwr = wr; x.iaddr = ad; x.iwd = wd; end
            else        begin x.dreq = rq; x.dwr = wr; x.daddr = ad; x.dwd = wd; end
        end
        x.rdone = ($urandom % 4 == 0);
        x.wdone = ($urandom % 4 == 0);
        x.rdata = {$urandom, $urandom, $urandom, $urandom};
        set_in(k, x);
    endtask

    vec_t tbl [7];
    localparam logic [127:0] LINE_A = 128'hDEAD_C0DE_1111_2222_3333_4444_5555_BEEF;
    localparam logic [127:0] LINE_W = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] LINE_Z = 128'hA5A5_5A5A_0F0F_F0F0_1357_9BDF_2468_ACE0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_t z;
        int  nb;
        z   = '0;
        in0 = z;
        in1 = z;
        hard_reset("reset");

        // Single I-cache read, then a D-cache write that ignores a read done.
        foreach (tbl[i]) begin
            tbl[i].in = z; tbl[i].breq = 0; tbl[i].baddr = 0; tbl[i].bwd = 0;
            tbl[i].idone = 0; tbl[i].ierr = 0; tbl[i].ddone = 0; tbl[i].derr = 0; tbl[i].rdbuf = LINE_A;
        end
        tbl[0].in.ireq = 1; tbl[0].in.iaddr = 32'h0000_1234;
        tbl[0].breq = 1; tbl[0].baddr = 32'h0000_1230; tbl[0].rdbuf = '0;
        tbl[1].in.ireq = 1; tbl[1].in.rdone = 1; tbl[1].in.rdata = LINE_A; tbl[1].idone = 1;
        tbl[3].in.dreq = 1; tbl[3].in.dwr = 1; tbl[3].in.daddr = 32'h8000_00FF; tbl[3].in.dwd = LINE_W;
        tbl[3].breq = 1; tbl[3].baddr = 32'h8000_00F0; tbl[3].bwd = LINE_W;
        tbl[4].in = tbl[3].in; tbl[4].in.dwd = LINE_Z; tbl[4].in.daddr = 32'h0000_0040;
        tbl[4].in.rdone = 1; tbl[4].in.rdata = LINE_Z;
        tbl[4].breq = 1; tbl[4].baddr = 32'h8000_00F0; tbl[4].bwd = LINE_W;
        tbl[5].in = tbl[4].in; tbl[5].in.rdone = 0; tbl[5].in.wdone = 1; tbl[5].ddone = 1;
        for (int i = 0; i < 7; i++) begin
            in0 = tbl[i].in;
            tick();
            chk($sformatf("tbl%0d_breq", i), o0.breq, tbl[i].breq);
            if (tbl[i].breq) begin
                chk($sformatf("tbl%0d_addr", i), o0.baddr, tbl[i].baddr);
                chk($sformatf("tbl%0d_wrtdata", i), o0.bwd, tbl[i].bwd);
            end
            chk($sformatf("tbl%0d_done_err", i), {o0.idone, o0.ierr, o0.ddone, o0.derr},
                {tbl[i].idone, tbl[i].ierr, tbl[i].ddone, tbl[i].derr});
            chk($sformatf("tbl%0d_rdbuf", i), o0.rdbuf, tbl[i].rdbuf);
        end

        // Simultaneous requests: round-robin gives I, D, I; priority gives D then I.
        in0 = z; in0.ireq = 1; in0.dreq = 1; in0.iaddr = 32'h100; in0.daddr = 32'h200;
        in1 = in0;
        tick();
        chk("rr_grant1_owner", o0.owner, 1'b0);
        chk("pri_grant1_owner", o1.owner, 1'b1);
        in0.rdone = 1; in1.rdone = 1; in0.rdata = LINE_W; in1.rdata = LINE_W;
        tick();
        chk("rr_done1", {o0.idone, o0.ddone}, 2'b10);
        chk("pri_done1", {o1.idone, o1.ddone}, 2'b01);
        in0.rdone = 0; in1.rdone = 0; in0.ireq = 0; in1.dreq = 0;
        tick();
        tick();
        chk("rr_grant2_owner", o0.owner, 1'b1);
        chk("pri_grant2_owner", {o1.breq, o1.owner}, 2'b10);
        in0.ireq = 1; in0.rdone = 1; in1.rdone = 1;
        tick();
        chk("rr_done2", {o0.idone, o0.ddone}, 2'b01);
        chk("pri_done2", {o1.idone, o1.ddone}, 2'b10);
        in0.rdone = 0; in1.rdone = 0; in0.dreq = 0; in1.ireq = 0;
        tick();
        tick();
        chk("rr_grant3_owner", {o0.breq, o0.owner}, 2'b10);
        chk("pri_idle", o1.breq, 1'b0);
        in0.rdone = 1;
        tick();
        chk("rr_done3", {o0.idone, o0.ddone}, 2'b10);
        in0 = z; in1 = z;
        tick();
        tick();

        // Timeout on dut0 with a mismatched done held high; dut1 never times out.
        in0.ireq = 1; in0.wdone = 1;
        in1.ireq = 1;
        tick();
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (!o0.breq) break;
            nb++;
            tick();
        end
        chk("timeout_busy_cycles", nb, 8);
        chk("timeout_done_err", {o0.idone, o0.ierr, o0.ddone}, 3'b110);
        chk("timeout_rdbuf", o0.rdbuf, '0);
        chk("no_timeout_busy", o1.breq, 1'b1);
        in0 = z; in1.rdone = 1; in1.rdata = LINE_Z;
        tick();
        chk("no_timeout_done", {o1.idone, o1.ierr}, 2'b10);
        in1 = z;
        tick();
        tick();

        // Reset while busy abandons the transaction; a held request is granted afresh.
        in0.ireq = 1; in1.dreq = 1;
        tick();
        chk("pre_reset_busy", {o0.breq, o1.breq}, 2'b11);
        #2;
        hard_reset("mid_reset");
        tick();
        chk("post_reset_grant", {o0.breq, o0.idone, o1.breq, o1.ddone}, 4'b1010);
        in0.rdone = 1; in1.rdone = 1;
        tick();
        chk("post_reset_done", {o0.idone, o1.ddone}, 2'b11);
        in0 = z; in1 = z;
        tick();
        tick();

        // Randomized traffic against the reference model.
        hard_reset("rand_reset");
        for (int cyc = 0; cyc < 1500; cyc++) begin
            agents(0);
            agents(1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
